// File: rtl/tb_uart.sv
// Full-duplex 8N1 UART endpoint for the chip's UART pins. TX is launched by a start/busy
// handshake; RX reports each byte with a one-cycle valid or frame-error strobe.
module tb_uart #(
  parameter int unsigned CLKS_PER_BIT = 347
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_clear_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);
  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        tx_state, tx_state_nxt;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_armed;
  logic          tx_launch, tx_bit_end;
  logic          ser_tx_nxt, tx_busy_nxt, tx_clear_nxt;

  assign tx_bit_end = (tx_cnt == BIT_LAST);
  assign tx_launch  = tx_start && tx_armed && (tx_state == S_IDLE);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) tx_state <= S_IDLE;
    else         tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      S_IDLE:  if (tx_launch)                    tx_state_nxt = S_START;
      S_START: if (tx_bit_end)                   tx_state_nxt = S_DATA;
      S_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_state_nxt = S_STOP;
      S_STOP:  if (tx_bit_end)                   tx_state_nxt = S_IDLE;
      default:                                   tx_state_nxt = S_IDLE;
    endcase
  end

  // Line value for the next bit is chosen at the end of the current one; shift holds bit n at [0].
  always_comb begin
    ser_tx_nxt   = ser_tx;
    tx_busy_nxt  = tx_busy;
    tx_clear_nxt = 1'b0;
    case (tx_state)
      S_IDLE:  if (tx_launch) begin
                 ser_tx_nxt  = 1'b0;
                 tx_busy_nxt = 1'b1;
               end
      S_START: if (tx_bit_end) ser_tx_nxt = tx_shift[0];
      S_DATA:  if (tx_bit_end) ser_tx_nxt = (tx_idx == 3'd7) ? 1'b1 : tx_shift[1];
      S_STOP:  if (tx_bit_end) begin
                 tx_busy_nxt  = 1'b0;
                 tx_clear_nxt = 1'b1;
               end
      default: ser_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tx_cnt       <= '0;
      tx_idx       <= '0;
      tx_shift     <= '0;
      tx_armed     <= 1'b1;
      ser_tx       <= 1'b1;
      tx_busy      <= 1'b0;
      tx_clear_req <= 1'b0;
    end else begin
      ser_tx       <= ser_tx_nxt;
      tx_busy      <= tx_busy_nxt;
      tx_clear_req <= tx_clear_nxt;
      if (!tx_start)      tx_armed <= 1'b1;
      else if (tx_launch) tx_armed <= 1'b0;
      if (tx_state == S_IDLE || tx_bit_end) tx_cnt <= '0;
      else                                  tx_cnt <= tx_cnt + CW'(1);
      if (tx_launch) begin
        tx_shift <= tx_data;
        tx_idx   <= '0;
      end else if (tx_state == S_DATA && tx_bit_end) begin
        tx_shift <= tx_shift >> 1;
        tx_idx   <= tx_idx + 3'd1;
      end
    end
  end

  state_t        rx_state, rx_state_nxt;
  logic          rx_s1, rx_s2, rx_wait_high;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_half, rx_bit_end;
  logic [7:0]    rx_data_nxt;
  logic          rx_valid_nxt, rx_err_nxt;

  assign rx_half    = (rx_cnt == HALF_LAST);
  assign rx_bit_end = (rx_cnt == BIT_LAST);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) rx_state <= S_IDLE;
    else         rx_state <= rx_state_nxt;
  end

  // After a bad stop bit, a new start is only accepted once the line has been seen high.
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      S_IDLE:  if (!rx_wait_high && !rx_s2)        rx_state_nxt = S_START;
      S_START: if (rx_half)                        rx_state_nxt = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_bit_end && rx_idx == 3'd7)   rx_state_nxt = S_STOP;
      S_STOP:  if (rx_bit_end)                     rx_state_nxt = S_IDLE;
      default:                                     rx_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_data_nxt  = rx_data;
    rx_valid_nxt = 1'b0;
    rx_err_nxt   = 1'b0;
    if (rx_state == S_STOP && rx_bit_end) begin
      if (rx_s2) begin
        rx_data_nxt  = rx_shift;
        rx_valid_nxt = 1'b1;
      end else begin
        rx_err_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_wait_high <= 1'b0;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1        <= ser_rx;
      rx_s2        <= rx_s1;
      rx_data      <= rx_data_nxt;
      rx_valid     <= rx_valid_nxt;
      rx_frame_err <= rx_err_nxt;
      if (rx_err_nxt)                           rx_wait_high <= 1'b1;
      else if (rx_state == S_IDLE && rx_s2)     rx_wait_high <= 1'b0;
      case (rx_state)
        S_START: rx_cnt <= rx_half ? '0 : rx_cnt + CW'(1);
        S_DATA,
        S_STOP:  rx_cnt <= rx_bit_end ? '0 : rx_cnt + CW'(1);
        default: rx_cnt <= '0;
      endcase
      if (rx_state == S_START) begin
        rx_idx <= '0;
      end else if (rx_state == S_DATA && rx_bit_end) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_idx   <= rx_idx + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_tb_uart.sv
// Scoreboarded bench for tb_uart: drivers push expected frames/bytes, line-level monitors pop and compare.
module tb_tb_uart;
  localparam int unsigned CPB   = 347;
  localparam int unsigned FRAME = 10 * CPB;

  typedef struct packed {
    logic       err;
    logic [7:0] d;
    longint     t;
  } rx_ev_t;

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       ser_rx = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ser_tx, tx_busy, tx_clear_req, rx_valid, rx_frame_err;
  logic [7:0] rx_data;

  int         n_tests = 0;
  int         n_fail = 0;
  longint     cyc = 0;
  logic [7:0] tx_exp[$];
  rx_ev_t     rx_exp[$];
  logic [7:0] last_rx = 8'h00;

  tb_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clock        (clock),
    .resetb       (resetb),
    .ser_rx       (ser_rx),
    .ser_tx       (ser_tx),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_clear_req (tx_clear_req),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_busy(input logic level, input int budget, input string name);
    int k;
    k = 0;
    while (tx_busy !== level && k < budget) begin
      @(negedge clock);
      k++;
    end
    check(name, 32'(tx_busy), 32'(level));
  endtask

  // Launch one frame, pulse tx_start mid-frame (must be ignored), wait for the clear request.
  task automatic send_tx(input logic [7:0] b);
    int k;
    wait_busy(1'b0, FRAME + 10, "tx_idle_wait");
    tx_start = 1'b0;
    @(negedge clock);
    tx_data  = b;
    tx_start = 1'b1;
    tx_exp.push_back(b);
    @(negedge clock);
    check("tx_launch", 32'(tx_busy), 1);
    wait_cycles(CPB);
    tx_start = 1'b0;
    @(negedge clock);
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    k = 0;
    while (tx_clear_req !== 1'b1 && k < int'(FRAME)) begin
      @(negedge clock);
      k++;
    end
    check("tx_clear_wait", 32'(tx_clear_req), 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    rx_ev_t     e;
    fr    = {stop, b, 1'b0};
    e.err = ~stop;
    e.d   = stop ? b : last_rx;
    e.t   = cyc;
    if (stop) last_rx = b;
    rx_exp.push_back(e);
    for (int i = 0; i < 10; i++) begin
      ser_rx = fr[i];
      wait_cycles(CPB);
    end
    ser_rx = 1'b1;
  endtask

  // TX monitor: every cycle of a frame must match the ideal 10-bit waveform of the expected byte.
  initial begin : tx_mon
    logic       prev, have, aborted;
    logic [9:0] fr;
    logic [7:0] eb;
    int         bad;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (resetb && prev && !ser_tx) begin
        have = (tx_exp.size() > 0);
        eb   = 8'h00;
        if (have) eb = tx_exp.pop_front();
        fr      = {1'b1, eb, 1'b0};
        bad     = 0;
        aborted = 1'b0;
        for (int k = 0; k < int'(FRAME); k++) begin
          if (k > 0) @(negedge clock);
          if (!resetb) begin
            aborted = 1'b1;
            break;
          end
          if (ser_tx !== fr[4'(k / int'(CPB))]) bad++;
        end
        if (!aborted) begin
          n_tests++;
          if (!have) begin
            n_fail++;
            $display("FAIL tx_unexpected_frame: a frame appeared on ser_tx, expected none");
          end else if (bad != 0) begin
            n_fail++;
            $display("FAIL tx_frame: byte 0x%02h had %0d wrong bit-cycles, expected 0", eb, bad);
          end
        end
      end
      prev = resetb ? ser_tx : 1'b1;
    end
  end

  // Busy monitor: each busy pulse lasts a full frame and ends together with tx_clear_req.
  initial begin : busy_mon
    int   len;
    logic prev;
    len  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!resetb) begin
        len  = 0;
        prev = 1'b0;
      end else begin
        if (prev && !tx_busy) begin
          check("busy_len", 32'(len), FRAME);
          check("clear_at_fall", 32'(tx_clear_req), 1);
          len = 0;
        end else if (tx_clear_req) begin
          check("clear_without_fall", 32'(tx_clear_req), 0);
        end
        if (tx_busy) len++;
        prev = tx_busy;
      end
    end
  end

  initial begin : rx_mon
    rx_ev_t e;
    longint lat;
    forever begin
      @(negedge clock);
      if (resetb && (rx_valid || rx_frame_err)) begin
        n_tests++;
        if (rx_exp.size() == 0) begin
          n_fail++;
          $display("FAIL rx_unexpected: valid=%0b err=%0b data=0x%02h, expected no rx output",
                   rx_valid, rx_frame_err, rx_data);
        end else begin
          e   = rx_exp.pop_front();
          lat = cyc - e.t;
          if (rx_valid && rx_frame_err) begin
            n_fail++;
            $display("FAIL rx_both_strobes: valid and err together, expected one");
          end else if (rx_frame_err !== e.err) begin
            n_fail++;
            $display("FAIL rx_kind: err=%0b, expected err=%0b", rx_frame_err, e.err);
          end else if (rx_data !== e.d) begin
            n_fail++;
            $display("FAIL rx_data: got 0x%02h, expected 0x%02h", rx_data, e.d);
          end else if (lat < longint'(9 * CPB) || lat > longint'(10 * CPB)) begin
            n_fail++;
            $display("FAIL rx_latency: %0d cycles, expected %0d..%0d", lat, 9 * CPB, 10 * CPB);
          end
        end
      end
    end
  end

  initial begin : watchdog
    wait (cyc > 95000);
    $display("FAIL watchdog: cycle budget exhausted, expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    // Reset with tx_start held high.
    resetb   = 1'b0;
    tx_start = 1'b1;
    wait_cycles(5);
    check("rst_ser_tx", 32'(ser_tx), 1);
    check("rst_tx_busy", 32'(tx_busy), 0);
    check("rst_clear_req", 32'(tx_clear_req), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_err", 32'(rx_frame_err), 0);
    tx_start = 1'b0;
    @(negedge clock);
    resetb = 1'b1;
    wait_cycles(5);
    check("post_rst_idle", 32'(tx_busy), 0);

    send_tx(8'hA5);

    // Holding tx_start sends one frame only; a 1-cycle drop re-arms.
    wait_busy(1'b0, FRAME + 10, "hold_pre_idle");
    tx_data  = 8'h5A;
    tx_start = 1'b1;
    tx_exp.push_back(8'h5A);
    @(negedge clock);
    check("hold_launch", 32'(tx_busy), 1);
    wait_busy(1'b0, FRAME + 10, "hold_end");
    wait_cycles(2 * CPB);
    check("hold_no_relaunch", 32'(tx_busy), 0);
    tx_start = 1'b0;
    @(negedge clock);
    tx_data  = 8'h01;
    tx_start = 1'b1;
    tx_exp.push_back(8'h01);
    @(negedge clock);
    check("rearm_launch", 32'(tx_busy), 1);
    wait_cycles(CPB);
    tx_start = 1'b0;
    @(negedge clock);
    tx_data  = 8'h02;
    tx_start = 1'b1;
    tx_exp.push_back(8'h02);
    wait_busy(1'b0, FRAME, "b2b_fall");
    @(negedge clock);
    check("b2b_relaunch", 32'(tx_busy), 1);
    wait_busy(1'b0, FRAME + 10, "b2b_end");
    tx_start = 1'b0;

    for (int i = 0; i < 2; i++) send_tx(8'($urandom()));

    // Back-to-back RX frames, starting with 0x3C.
    send_rx(8'h3C, 1'b1);
    for (int i = 0; i < 2; i++) send_rx(8'($urandom()), 1'b1);
    wait_cycles(CPB);

    send_rx(8'($urandom()), 1'b0);
    wait_cycles(CPB);

    ser_rx = 1'b0;
    wait_cycles(CPB / 4);
    ser_rx = 1'b1;
    wait_cycles(2 * CPB);
    check("glitch_rx_data", 32'(rx_data), 32'(last_rx));

    fork
      begin
        send_tx(8'h00);
        send_tx(8'h01);
        send_tx(8'h02);
      end
      begin
        send_rx(8'hAB, 1'b1);
        send_rx(8'h01, 1'b1);
        send_rx(8'($urandom()), 1'b1);
        send_rx(8'($urandom()), 1'b1);
      end
    join
    wait_cycles(2 * CPB);

    // Reset in the middle of an all-zero frame must force the line high at once.
    wait_busy(1'b0, FRAME + 10, "midrst_pre_idle");
    tx_data  = 8'h00;
    tx_start = 1'b1;
    @(negedge clock);
    check("midrst_launch", 32'(tx_busy), 1);
    wait_cycles(3 * CPB + CPB / 2);
    #2 resetb = 1'b0;
    #1;
    check("midrst_ser_tx", 32'(ser_tx), 1);
    check("midrst_busy", 32'(tx_busy), 0);
    check("midrst_rx_data", 32'(rx_data), 0);
    last_rx  = 8'h00;
    tx_start = 1'b0;
    wait_cycles(3);
    resetb = 1'b1;
    wait_cycles(2 * CPB);
    check("midrst_idle_after", 32'(tx_busy), 0);
    check("midrst_line_idle", 32'(ser_tx), 1);

    check("tx_queue_empty", 32'(tx_exp.size()), 0);
    check("rx_queue_empty", 32'(rx_exp.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
